noise_channel: RTL
==================

Name: noise_channel

Overview:
- Control stage wrapped around the noise LFSR in the APU.
- Upstream of the LFSR: decodes CPU writes to the noise registers ($400C/$400E/$400F), runs the period timer that produces `next_step`, and supplies `mode`.
- Downstream of the LFSR: takes `noise_raw` back, applies envelope/constant volume and length-counter gating, and delivers the 4-bit noise sample to the mixer.

Parameters:
- PERIOD_W, 12, width of the period timer counter. Must hold 4067.
- LEN_W, 8, width of the length counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_en  in  1  CPU-cycle enable; all state advances only when high
- quarter_frame  in  1  frame-sequencer quarter-frame tick; qualified by cpu_en
- half_frame  in  1  frame-sequencer half-frame tick; qualified by cpu_en
- reg_we  in  1  register write strobe; qualified by cpu_en
- reg_addr  in  2  0=$400C, 1=$400D (ignored), 2=$400E, 3=$400F
- reg_wdata  in  8  write data
- ch_enable  in  1  $4015 bit 3
- noise_raw  in  1  LFSR output; 1 = sound enabled
- next_step  out  1  to LFSR; high when the timer is 0
- mode  out  1  to LFSR; $400E bit 7
- sound  out  4  noise sample to mixer
- length_active  out  1  length counter != 0; for $4015 reads

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high. Reset is not gated by cpu_en.
- Reset clears: all registers, timer, length counter, envelope divider, decay and start flag.
- Outputs after reset: next_step=1, mode=0, sound=0, length_active=0.
- Register map (write only; `tick` = cpu_en & reg_we):
  - $400C: bit5 = halt/loop, bit4 = const, bits3:0 = V.
  - $400E: bit7 = mode, bits3:0 = period index.
  - $400F: bits7:3 = length index. If ch_enable is high, the length counter loads LEN_TABLE[index]. The envelope start flag is set regardless of ch_enable.
- Period table, in CPU cycles, index 0..15: 4,8,16,32,64,96,128,160,202,254,380,508,762,1016,2034,4068.
- Timer, on each cpu_en:
  - If timer==0: reload to table[idx]-1.
  - Else: decrement.
  - next_step = (timer==0), combinational. The LFSR itself qualifies it with cpu_en, so it shifts exactly once per period.
  - A period write takes effect at the next reload; the current count is not disturbed.
- Length table, index 0..31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Length counter:
  - On cpu_en & half_frame: if len!=0 and halt==0, decrement.
  - $400F load in the same cycle as half_frame: the load wins.
  - ch_enable low: len is forced to 0 every cycle, and loads are suppressed.
- Envelope, on cpu_en & quarter_frame:
  - If start: clear start, decay=15, divider=V.
  - Else if divider==0: divider=V; then if decay!=0, decrement decay; else if loop, decay=15.
  - Else: decrement divider.
  - $400F write in the same cycle as quarter_frame: start is set, and is consumed on the next quarter_frame, not this one.
- Output (combinational from registered state):
  - sound = 0 if len==0 or noise_raw==0.
  - Otherwise sound = V when const=1, else decay.
- length_active = (len!=0).
- cpu_en low: no state changes at all. Writes and frame ticks in that cycle are ignored.

Test Plan:
- Timer period: write $400E=0x00 and hold cpu_en=1 → next_step high once every 4 cycles. Write $400E=0x8F → mode=1, and from the next reload the spacing between next_step pulses is 4068 cycles.
- Length load and count: ch_enable=1; write $400C=0x10 (const, V=0), then $400F=0x08 (index 1) → length_active=1, len=254. Apply 254 half_frame ticks → length_active=0 exactly on the 254th.
- Halt and disable: $400C=0x3F, load len=10, apply 20 half_frames → len stays 10. Drop ch_enable → length_active=0 the next cycle. A $400F write while disabled → length_active remains 0.
- Envelope decay: $400C=0x01 (V=1, no loop), write $400F, hold noise_raw=1 and len!=0 → first quarter_frame gives sound=15. After that sound decrements by 1 every 2 quarter_frames and holds at 0. Repeat with $400C=0x21 (loop) → sound wraps 0→15.
- Constant volume and gating: $400C=0x17 → sound=7 while noise_raw=1, and 0 while noise_raw=0. Let len reach 0 → sound=0 even with noise_raw=1.
- Reset and simultaneous events: mid-count, apply reset together with reg_we → all outputs return to reset values and the write is ignored. $400F write coincident with half_frame → len equals the table value, not table-1.

Source files
------------

// File: rtl/noise_channel.sv
// APU noise channel control: register decode, period timer feeding the LFSR,
// length counter, envelope generator and output gating toward the mixer.
module noise_channel #(
  parameter int PERIOD_W = 12,
  parameter int LEN_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       quarter_frame,
  input  logic       half_frame,
  input  logic       reg_we,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  input  logic       ch_enable,
  input  logic       noise_raw,
  output logic       next_step,
  output logic       mode,
  output logic [3:0] sound,
  output logic       length_active
);

  logic                halt;
  logic                const_vol;
  logic [3:0]          vol;
  logic [3:0]          period_idx;
  logic [PERIOD_W-1:0] timer;
  logic [LEN_W-1:0]    len;
  logic [3:0]          env_div;
  logic [3:0]          decay;
  logic                env_start;

  logic wr_ctrl;
  logic wr_period;
  logic wr_length;

  // Reload value is the table period minus one so a full period spans timer..0.
  function automatic logic [PERIOD_W-1:0] period_reload(input logic [3:0] idx);
    case (idx)
      4'd0:    period_reload = PERIOD_W'(3);
      4'd1:    period_reload = PERIOD_W'(7);
      4'd2:    period_reload = PERIOD_W'(15);
      4'd3:    period_reload = PERIOD_W'(31);
      4'd4:    period_reload = PERIOD_W'(63);
      4'd5:    period_reload = PERIOD_W'(95);
      4'd6:    period_reload = PERIOD_W'(127);
      4'd7:    period_reload = PERIOD_W'(159);
      4'd8:    period_reload = PERIOD_W'(201);
      4'd9:    period_reload = PERIOD_W'(253);
      4'd10:   period_reload = PERIOD_W'(379);
      4'd11:   period_reload = PERIOD_W'(507);
      4'd12:   period_reload = PERIOD_W'(761);
      4'd13:   period_reload = PERIOD_W'(1015);
      4'd14:   period_reload = PERIOD_W'(2033);
      default: period_reload = PERIOD_W'(4067);
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] length_value(input logic [4:0] idx);
    case (idx)
      5'd0:    length_value = LEN_W'(10);
      5'd1:    length_value = LEN_W'(254);
      5'd2:    length_value = LEN_W'(20);
      5'd3:    length_value = LEN_W'(2);
      5'd4:    length_value = LEN_W'(40);
      5'd5:    length_value = LEN_W'(4);
      5'd6:    length_value = LEN_W'(80);
      5'd7:    length_value = LEN_W'(6);
      5'd8:    length_value = LEN_W'(160);
      5'd9:    length_value = LEN_W'(8);
      5'd10:   length_value = LEN_W'(60);
      5'd11:   length_value = LEN_W'(10);
      5'd12:   length_value = LEN_W'(14);
      5'd13:   length_value = LEN_W'(12);
      5'd14:   length_value = LEN_W'(26);
      5'd15:   length_value = LEN_W'(14);
      5'd16:   length_value = LEN_W'(12);
      5'd17:   length_value = LEN_W'(16);
      5'd18:   length_value = LEN_W'(24);
      5'd19:   length_value = LEN_W'(18);
      5'd20:   length_value = LEN_W'(48);
      5'd21:   length_value = LEN_W'(20);
      5'd22:   length_value = LEN_W'(96);
      5'd23:   length_value = LEN_W'(22);
      5'd24:   length_value = LEN_W'(192);
      5'd25:   length_value = LEN_W'(24);
      5'd26:   length_value = LEN_W'(72);
      5'd27:   length_value = LEN_W'(26);
      5'd28:   length_value = LEN_W'(16);
      5'd29:   length_value = LEN_W'(28);
      5'd30:   length_value = LEN_W'(32);
      default: length_value = LEN_W'(30);
    endcase
  endfunction

  assign wr_ctrl   = reg_we && (reg_addr == 2'd0);
  assign wr_period = reg_we && (reg_addr == 2'd2);
  assign wr_length = reg_we && (reg_addr == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      halt       <= 1'b0;
      const_vol  <= 1'b0;
      vol        <= 4'd0;
      mode       <= 1'b0;
      period_idx <= 4'd0;
    end else if (cpu_en) begin
      if (wr_ctrl) begin
        halt      <= reg_wdata[5];
        const_vol <= reg_wdata[4];
        vol       <= reg_wdata[3:0];
      end
      if (wr_period) begin
        mode       <= reg_wdata[7];
        period_idx <= reg_wdata[3:0];
      end
    end
  end

  // The reload reads the index already registered, so a new period never
  // disturbs a count in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (cpu_en) begin
      if (timer == '0) begin
        timer <= period_reload(period_idx);
      end else begin
        timer <= timer - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len <= '0;
    end else if (cpu_en) begin
      if (!ch_enable) begin
        len <= '0;
      end else if (wr_length) begin
        len <= length_value(reg_wdata[7:3]);
      end else if (half_frame && (len != '0) && !halt) begin
        len <= len - 1'b1;
      end
    end
  end

  // A $400F write sets start after the quarter-frame update, so a coincident
  // quarter-frame does not consume it.
  always_ff @(posedge clk) begin
    if (reset) begin
      env_div   <= 4'd0;
      decay     <= 4'd0;
      env_start <= 1'b0;
    end else if (cpu_en) begin
      if (quarter_frame) begin
        if (env_start) begin
          env_start <= 1'b0;
          decay     <= 4'd15;
          env_div   <= vol;
        end else if (env_div == 4'd0) begin
          env_div <= vol;
          if (decay != 4'd0) begin
            decay <= decay - 1'b1;
          end else if (halt) begin
            decay <= 4'd15;
          end
        end else begin
          env_div <= env_div - 1'b1;
        end
      end
      if (wr_length) begin
        env_start <= 1'b1;
      end
    end
  end

  assign next_step     = (timer == '0);
  assign length_active = (len != '0);

  always_comb begin
    sound = 4'd0;
    if ((len != '0) && noise_raw) begin
      sound = const_vol ? vol : decay;
    end
  end

endmodule
